// File: rtl/lint_l2_interleaved_mem_if.sv
// Lint/TCDM request bus bundle for NB_MASTERS masters. Per-master fields are packed
// flat, with master m occupying slice [m*W +: W].
interface lint_l2_interleaved_mem_if #(
  parameter int NB_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_MASTERS-1:0]            req;
  logic [NB_MASTERS*ADDR_WIDTH-1:0] add;
  logic [NB_MASTERS-1:0]            wen;
  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata;
  logic [NB_MASTERS*BE_WIDTH-1:0]   be;
  logic [NB_MASTERS-1:0]            gnt;
  logic [NB_MASTERS-1:0]            r_valid;
  logic [NB_MASTERS*DATA_WIDTH-1:0] r_rdata;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata
  );
endinterface

// File: rtl/lint_l2_interleaved_mem.sv
// Multi-master, word-interleaved L2 memory. It uses one round-robin arbiter per bank
// and zeroes every row after reset before it issues any grant.
module lint_l2_interleaved_mem #(
  parameter int NB_MASTERS = 2,
  parameter int NB_BANKS   = 4,
  parameter int BANK_WORDS = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  lint_l2_interleaved_mem_if.slave bus,
  output logic                     init_done_o
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BE_WIDTH);
  localparam int BANK_W   = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;
  localparam int ROW_W    = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int MST_W    = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [MST_W-1:0]      rr_q [NB_BANKS];
  logic [MST_W-1:0]      rr_d [NB_BANKS];
  logic [NB_MASTERS-1:0] gnt;
  logic [NB_MASTERS-1:0] r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q [NB_MASTERS];
  logic [DATA_WIDTH-1:0] rdata_d [NB_MASTERS];

  logic [BANK_W-1:0]     m_bank [NB_MASTERS];
  logic [ROW_W-1:0]      m_row  [NB_MASTERS];

  logic                  bank_we    [NB_BANKS];
  logic [ROW_W-1:0]      bank_row   [NB_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NB_BANKS];
  logic [BE_WIDTH-1:0]   bank_be    [NB_BANKS];

  logic [DATA_WIDTH-1:0] sram [NB_BANKS][BANK_WORDS];

  // Upper address bits fall away in the modulo, so addresses alias across the total size.
  always_comb begin
    for (int m = 0; m < NB_MASTERS; m++) begin
      m_bank[m] = BANK_W'((bus.add[m*ADDR_WIDTH +: ADDR_WIDTH] >> OFF_BITS) % NB_BANKS);
      m_row[m]  = ROW_W'(((bus.add[m*ADDR_WIDTH +: ADDR_WIDTH] >> OFF_BITS) / NB_BANKS)
                         % BANK_WORDS);
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    if (state_q == INIT) begin
      row_cnt_d = row_cnt_q + 1'b1;
      if (row_cnt_q == ROW_W'(BANK_WORDS - 1)) begin
        state_d = READY;
      end
    end
  end

  always_comb begin
    logic             found;
    logic [MST_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      rr_d[b]       = rr_q[b];
      bank_we[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      bank_be[b]    = '0;
    end
    if (state_q == INIT) begin
      for (int b = 0; b < NB_BANKS; b++) begin
        bank_we[b]  = 1'b1;
        bank_row[b] = row_cnt_q;
        bank_be[b]  = '1;
      end
    end else begin
      // Scan upward from each bank's pointer so the last winner drops to lowest priority.
      for (int b = 0; b < NB_BANKS; b++) begin
        found = 1'b0;
        for (int i = 0; i < NB_MASTERS; i++) begin
          idx = MST_W'((int'(rr_q[b]) + i) % NB_MASTERS);
          if (!found && bus.req[idx] && (m_bank[idx] == BANK_W'(b))) begin
            found         = 1'b1;
            gnt[idx]      = 1'b1;
            rr_d[b]       = MST_W'((int'(idx) + 1) % NB_MASTERS);
            bank_we[b]    = ~bus.wen[idx];
            bank_row[b]   = m_row[idx];
            bank_wdata[b] = bus.wdata[idx*DATA_WIDTH +: DATA_WIDTH];
            bank_be[b]    = bus.be[idx*BE_WIDTH +: BE_WIDTH];
          end
        end
      end
    end
  end

  // Only one master can win a bank, so a granted read never collides with a write.
  always_comb begin
    r_valid_d = gnt;
    for (int m = 0; m < NB_MASTERS; m++) begin
      rdata_d[m] = rdata_q[m];
      if (gnt[m] && bus.wen[m]) begin
        rdata_d[m] = sram[m_bank[m]][m_row[m]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT;
      row_cnt_q <= '0;
      r_valid_q <= '0;
      for (int b = 0; b < NB_BANKS; b++) rr_q[b] <= '0;
      for (int m = 0; m < NB_MASTERS; m++) rdata_q[m] <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      r_valid_q <= r_valid_d;
      for (int b = 0; b < NB_BANKS; b++) rr_q[b] <= rr_d[b];
      for (int m = 0; m < NB_MASTERS; m++) rdata_q[m] <= rdata_d[m];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (bank_we[b] && bank_be[b][k]) begin
          sram[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    bus.gnt     = gnt;
    bus.r_valid = r_valid_q;
    bus.r_rdata = '0;
    for (int m = 0; m < NB_MASTERS; m++) begin
      bus.r_rdata[m*DATA_WIDTH +: DATA_WIDTH] = rdata_q[m];
    end
  end

  assign init_done_o = (state_q == READY);
endmodule

// File: tb/tb_lint_l2_interleaved_mem.sv
// Directed scoreboard bench for lint_l2_interleaved_mem. It uses 2 masters and
// 4 banks of 64 words of 32 bits.
module tb_lint_l2_interleaved_mem;
  logic clk;
  logic rst_n;
  logic init_done;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    int          cyc;
    bit          is_read;
    logic [31:0] data;
  } resp_t;

  resp_t      exp_q [2][$];
  logic [1:0] contention_pat [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  lint_l2_interleaved_mem_if #(.NB_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lint_l2_interleaved_mem #(
    .NB_MASTERS(2), .NB_BANKS(4), .BANK_WORDS(64), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .init_done_o (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // The monitor pops a scoreboard entry on every r_valid and flags any response that went missing.
  always @(negedge clk) begin
    resp_t e;
    for (int m = 0; m < 2; m++) begin
      while (exp_q[m].size() > 0 && exp_q[m][0].cyc < cyc) begin
        e = exp_q[m].pop_front();
        check_output("rvalid_missing", 64'(0), 64'(1));
      end
      if (bus.r_valid[m]) begin
        if (exp_q[m].size() == 0) begin
          check_output("rvalid_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q[m].pop_front();
          check_output("rvalid_cycle", 64'(cyc), 64'(e.cyc));
          if (e.is_read) check_output("rdata", 64'(bus.r_rdata[m*32 +: 32]), 64'(e.data));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int m, logic [31:0] a, logic w, logic [31:0] d, logic [3:0] b);
    bus.req[m]         = 1'b1;
    bus.add[m*32 +: 32] = a;
    bus.wen[m]         = w;
    bus.wdata[m*32 +: 32] = d;
    bus.be[m*4 +: 4]   = b;
  endtask

  task automatic push_resp(int m, bit rd, logic [31:0] d);
    resp_t e;
    e.cyc     = cyc + 1;
    e.is_read = rd;
    e.data    = d;
    exp_q[m].push_back(e);
  endtask

  task automatic apply_stimulus(int m, logic [31:0] a, logic w, logic [31:0] d,
                                logic [3:0] b, logic [31:0] exp_data);
    bit ok;
    ok = 1'b0;
    drive(m, a, w, d, b);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt[m]) begin
        push_resp(m, w, exp_data);
        ok = 1'b1;
        break;
      end
    end
    check_output("gnt_timeout", 64'(ok), 64'(1));
    next_cycle();
    bus.req[m] = 1'b0;
  endtask

  // The caller holds reset low. Master 0 keeps a read of 0x0 pending across the whole sweep.
  task automatic init_sweep();
    int cnt;
    bit early;
    bit got;
    cnt   = 0;
    early = 1'b0;
    got   = 1'b0;
    drive(0, 32'h0, 1'b1, 32'h0, 4'h0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.gnt[0]) begin
        got = 1'b1;
        break;
      end
      if (init_done) early = 1'b1;
      cnt++;
    end
    check_output("init_gnt_seen", 64'(got), 64'(1));
    check_output("init_gnt_low_cycles", 64'(cnt), 64'(64));
    check_output("init_done_early", 64'(early), 64'(0));
    check_output("init_done_rise", 64'(init_done), 64'(1));
    if (got) push_resp(0, 1'b1, 32'h0);
    next_cycle();
    bus.req[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.add   = '0;
    bus.wen   = '0;
    bus.wdata = '0;
    bus.be    = '0;

    repeat (3) next_cycle();
    @(negedge clk);
    check_output("reset_gnt", 64'(bus.gnt), 64'(0));
    check_output("reset_rvalid", 64'(bus.r_valid), 64'(0));
    check_output("reset_rdata", bus.r_rdata, 64'(0));
    check_output("reset_init_done", 64'(init_done), 64'(0));

    init_sweep();

    apply_stimulus(0, 32'h10, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0);
    apply_stimulus(0, 32'h10, 1'b0, 32'h00001234, 4'h3, 32'h0);
    apply_stimulus(0, 32'h10, 1'b1, 32'h0, 4'h0, 32'hDEAD1234);

    apply_stimulus(0, 32'h0, 1'b0, 32'h11111111, 4'hF, 32'h0);
    apply_stimulus(1, 32'h4, 1'b0, 32'h22222222, 4'hF, 32'h0);
    drive(0, 32'h0, 1'b1, 32'h0, 4'h0);
    drive(1, 32'h4, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    check_output("parallel_gnt", 64'(bus.gnt), 64'(2'b11));
    if (bus.gnt[0]) push_resp(0, 1'b1, 32'h11111111);
    if (bus.gnt[1]) push_resp(1, 1'b1, 32'h22222222);
    next_cycle();
    bus.req = '0;

    // The pointer for bank 2 returns to master 0 after these two writes.
    apply_stimulus(0, 32'h8, 1'b0, 32'hAAAA0008, 4'hF, 32'h0);
    apply_stimulus(1, 32'h18, 1'b0, 32'hBBBB0018, 4'hF, 32'h0);
    drive(0, 32'h8, 1'b1, 32'h0, 4'h0);
    drive(1, 32'h18, 1'b1, 32'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("contention_gnt", 64'(bus.gnt), 64'(contention_pat[c]));
      if (bus.gnt[0]) push_resp(0, 1'b1, 32'hAAAA0008);
      if (bus.gnt[1]) push_resp(1, 1'b1, 32'hBBBB0018);
      next_cycle();
    end
    bus.req = '0;

    apply_stimulus(0, 32'h0, 1'b0, 32'hA5A5A5A5, 4'hF, 32'h0);
    apply_stimulus(1, 32'h400, 1'b1, 32'h0, 4'h0, 32'hA5A5A5A5);
    apply_stimulus(0, 32'h403, 1'b1, 32'h0, 4'h0, 32'hA5A5A5A5);

    drive(0, 32'h10, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    check_output("midreset_gnt", 64'(bus.gnt[0]), 64'(1));
    next_cycle();
    rst_n   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check_output("midreset_rvalid", 64'(bus.r_valid), 64'(0));
    check_output("midreset_rdata", bus.r_rdata, 64'(0));
    check_output("midreset_init_done", 64'(init_done), 64'(0));
    next_cycle();

    init_sweep();
    apply_stimulus(0, 32'h10, 1'b1, 32'h0, 4'h0, 32'h0);
    apply_stimulus(1, 32'h18, 1'b1, 32'h0, 4'h0, 32'h0);
    apply_stimulus(1, 32'h4, 1'b1, 32'h0, 4'h0, 32'h0);

    repeat (3) next_cycle();
    check_output("queue0_drained", 64'(exp_q[0].size()), 64'(0));
    check_output("queue1_drained", 64'(exp_q[1].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
